// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, a small in-order
// instruction buffer, and branch redirect with drain of any stale in-flight response.
module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2        // 2 or 4
) (
  input  logic        CLK,
  input  logic        nReset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] Instruction,
  output logic [10:0] op,
  output logic [63:0] inst_pc,
  input  logic        Branch,
  input  logic        UncondBranch,
  input  logic        Zero,
  input  logic [63:0] branch_target
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t        r_state;
  logic [63:0]   r_pc;
  logic [63:0]   r_req_pc;
  logic [31:0]   r_inst [BUF_DEPTH];
  logic [63:0]   r_ipc  [BUF_DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_taken;
  logic          w_xfer;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  assign w_taken     = UncondBranch | (Branch & Zero);
  assign w_xfer      = imem_req_valid & imem_req_ready;
  // A redirect squashes both ends of the buffer in the same cycle.
  assign w_push      = imem_rsp_valid & (r_state == S_WAIT) & ~w_taken;
  assign w_pop       = inst_valid & inst_ready & ~w_taken;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign imem_req_valid = nReset & (r_state == S_REQ);
  assign imem_addr      = r_pc;
  assign inst_valid     = (r_count != '0);
  assign Instruction    = r_inst[r_head];
  assign op             = Instruction[31:21];
  assign inst_pc        = r_ipc[r_head];

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_inst[i] <= '0;
        r_ipc[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_inst[r_tail] <= imem_rsp_data;
        r_ipc[r_tail]  <= r_req_pc;
        r_tail         <= r_tail + AW'(1);
      end
      if (w_pop)
        r_head <= r_head + AW'(1);
      if (w_xfer)
        r_req_pc <= r_pc;

      if (w_taken) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_pc    <= branch_target & ~64'h3;
        // Anything still in flight after this edge must be thrown away.
        if (w_xfer || (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_rsp_valid))
          r_state <= S_DRAIN;
        else
          r_state <= S_REQ;
      end else begin
        r_count <= w_count_nxt;
        if (w_xfer)
          r_pc <= r_pc + 64'd4;
        case (r_state)
          S_REQ:   if (w_xfer) r_state <= S_WAIT;
          S_WAIT:  if (imem_rsp_valid)
                     r_state <= (w_count_nxt == CW'(BUF_DEPTH)) ? S_HOLD : S_REQ;
          S_HOLD:  if (w_pop) r_state <= S_REQ;
          S_DRAIN: if (imem_rsp_valid) r_state <= S_REQ;
          default: r_state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Parameters
REQ-001 RESET_PC, default 64'h0, byte address of the first fetched instruction.
REQ-002 BUF_DEPTH, default 2, number of instruction-buffer entries; legal values are 2 and 4 only.

Interface
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  instruction-memory request valid.
REQ-006 imem_req_ready  input  1  instruction memory accepts the request this cycle.
REQ-007 imem_addr  output  64  request byte address, held stable while imem_req_valid=1 and imem_req_ready=0.
REQ-008 imem_rsp_valid  input  1  response data valid; exactly one response per accepted request, in order, at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  input  32  instruction word.
REQ-010 inst_valid  output  1  buffer head holds a valid instruction.
REQ-011 inst_ready  input  1  decode consumes the head this cycle.
REQ-012 Instruction  output  32  head instruction word.
REQ-013 op  output  11  Instruction[31:21], driven to the Control decoder.
REQ-014 inst_pc  output  64  byte address of the head instruction.
REQ-015 Branch, UncondBranch, Zero  input  1 each  resolved branch controls from execute.
REQ-016 branch_target  input  64  resolved target byte address, valid when the branch is taken.

Function
REQ-017 Branch taken = UncondBranch | (Branch & Zero), sampled every cycle.
REQ-018 Request handshake: a request transfers when imem_req_valid & imem_req_ready; at most one request is outstanding at a time.
REQ-019 Fetch PC increments by 4 on each request transfer; wrap-around from 64'hFFFF_FFFF_FFFF_FFFC to 0 is modular, with no flag.
REQ-020 FSM states:
- REQ: imem_req_valid=1.
- WAIT: request outstanding, imem_req_valid=0.
- HOLD: buffer entries + outstanding = BUF_DEPTH, imem_req_valid=0.
REQ-021 Transitions:
- REQ->WAIT on transfer.
- WAIT->REQ on response when space remains.
- WAIT->HOLD on response when the buffer is full.
- HOLD->REQ when an entry is consumed.
REQ-022 Responses are written into the buffer tail together with the PC of their request; latency from imem_rsp_valid to inst_valid is 1 cycle.
REQ-023 Buffer handshake: the head is popped when inst_valid & inst_ready; a pop and a push in the same cycle are both performed and the count is unchanged.
REQ-024 A push into a full buffer shall never occur, which is guaranteed by the credit rule in REQ-020.
REQ-025 Inst_valid=0 implies Instruction, op and inst_pc are don't-care; the bench shall not check them.
REQ-026 Redirect on a taken branch, applied on the next edge:
- fetch PC <= branch_target;
- buffer flushed, including any same-cycle push;
- a same-cycle pop is ignored;
- the FSM goes to REQ, or to DRAIN if a request is outstanding.
REQ-027 DRAIN: imem_req_valid=0; the next response is discarded; then go to REQ.
REQ-028 A taken branch during DRAIN updates the fetch PC and stays in DRAIN.
REQ-029 A taken branch in the same cycle as a request transfer counts that request as outstanding, so its response is discarded.
REQ-030 branch_target[1:0] is ignored and treated as 2'b00.

Reset
REQ-031 While nReset=0, outputs are forced to: imem_req_valid=0, imem_addr=RESET_PC, inst_valid=0, Instruction=0, op=0, inst_pc=0.
REQ-032 While nReset=0, internal state is forced to: buffer empty, no outstanding request, FSM in REQ.
REQ-033 Reset assertion mid-transaction takes effect immediately, and any in-flight response is not required to be discarded by the memory.
REQ-034 The first request asserts in the first cycle after reset deassertion.

Verification
REQ-035 Reset release with memory ready every cycle and 1-cycle response latency -> addresses 0x0, 0x4, 0x8 issued; inst_valid rises 2 cycles after the first request transfer with inst_pc=0.
REQ-036 inst_ready=0 held, BUF_DEPTH=2 -> exactly 2 requests issued, then imem_req_valid=0; one pop -> the request at 0x8 issues on the next cycle.
REQ-037 UncondBranch=1, branch_target=0x100, while the request at 0xC is outstanding -> 0xC response dropped, buffer empty, next request address 0x100, inst_pc=0x100 delivered first.
REQ-038 Branch=1, Zero=0 -> no redirect, sequence continues; then Branch=1, Zero=1, target=0x40 -> redirect to 0x40.
REQ-039 Response with data 32'hF8400000 -> op=11'b11111000010 (LDUR), Instruction matches, in the same cycle inst_valid=1.
REQ-040 nReset pulsed low during WAIT -> all outputs at reset values immediately; after release, fetch restarts at RESET_PC.
